// File: rtl/tank_trouble_soc_pulse_pio.sv
// Avalon-MM parallel output port with a one-shot pulse engine: a mask write
// inverts selected DATA bits for PULSE_LEN cycles, then flags done / irq.
module tank_trouble_soc_pulse_pio #(
    parameter int          DATA_WIDTH  = 8,
    parameter int unsigned RESET_VALUE = 0,
    parameter int          LEN_WIDTH   = 16,
    parameter int unsigned DEFAULT_LEN = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam logic [DATA_WIDTH-1:0] RST_DATA = DATA_WIDTH'(RESET_VALUE);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  RST_LEN  = LEN_WIDTH'(DEFAULT_LEN);
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  irq_en_q, irq_en_d;
    logic                  irq_q, irq_d;

    logic                  wr_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [LEN_WIDTH-1:0]  wlen_s;
    logic                  wr_unused_s;

    assign wr_s        = chipselect & ~write_n;
    assign wdata_s     = writedata[DATA_WIDTH-1:0];
    assign wlen_s      = writedata[LEN_WIDTH-1:0];
    assign wr_unused_s = ^writedata;

    // Register writes, pulse FSM and countdown; done set is applied after w1c so set wins.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        mask_d   = mask_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        irq_en_d = irq_en_q;

        if (wr_s) begin
            case (address)
                3'd0: data_d = wdata_s;
                3'd1: data_d = data_q | wdata_s;
                3'd2: data_d = data_q & ~wdata_s;
                3'd3: begin
                    if ((state_q == ST_IDLE) && (wdata_s != DATA_ZERO)) begin
                        mask_d  = wdata_s;
                        cnt_d   = (len_q == LEN_ZERO) ? LEN_ONE : len_q;
                        state_d = ST_ACTIVE;
                    end else begin
                        mask_d = mask_q;
                    end
                end
                3'd4: len_d = wlen_s;
                3'd5: begin
                    if (writedata[1]) begin
                        done_d = 1'b0;
                    end else begin
                        done_d = done_q;
                    end
                end
                3'd6: irq_en_d = writedata[0];
                default: data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end

        case (state_q)
            ST_ACTIVE: begin
                if (cnt_q == LEN_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = LEN_ZERO;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                end
            end
            ST_IDLE:  state_d = state_d;
            default:  state_d = ST_IDLE;
        endcase

        out_d = data_d ^ (mask_d & {DATA_WIDTH{state_d == ST_ACTIVE}});
        irq_d = done_d & irq_en_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            data_q   <= RST_DATA;
            mask_q   <= DATA_ZERO;
            len_q    <= RST_LEN;
            cnt_q    <= LEN_ZERO;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            out_q    <= RST_DATA;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            out_q    <= out_d;
            irq_q    <= irq_d;
        end
    end

    // Zero-wait-state read mux, not gated by chipselect.
    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0: readdata[DATA_WIDTH-1:0] = data_q;
            3'd3: readdata[DATA_WIDTH-1:0] = mask_q;
            3'd4: readdata[LEN_WIDTH-1:0]  = len_q;
            3'd5: readdata[1:0]            = {done_q, state_q == ST_ACTIVE};
            3'd6: readdata[0]              = irq_en_q;
            default: readdata = 32'd0;
        endcase
    end

    assign out_port = out_q;
    assign irq      = irq_q;

endmodule
